// File: rtl/alu_bridge_pkg.sv
// Shared types and constants for the ALU <-> UART command bridge.
// Contents: bridge FSM state enum, status byte bit positions, error status code,
// and a helper for sizing byte-index counters.
package alu_bridge_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRxA,
    StRxB,
    StExec,
    StWaitAlu,
    StTxByte,
    StTxAck,
    StTxStat,
    StTxStatAck
  } bridge_state_e;

  // Status byte bit positions
  localparam int unsigned STAT_OVF  = 0;
  localparam int unsigned STAT_ZERO = 1;
  localparam int unsigned STAT_ERR  = 7;

  // Status returned for a command byte with nonzero reserved bits
  localparam logic [7:0] ERR_RESERVED = 8'h80;

  // Width of a counter indexing nb bytes (at least one bit)
  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/alu_uart_bridge_if.sv
// Bus bundle between the bridge and its environment (UART and ALU).
// master: the bridge side (drives TX request, ALU operands, busy, frame_err).
// slave : the environment side (drives RX bytes, TXbusy, ALU result/done).
interface alu_uart_bridge_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 2
);
  logic [7:0]        RXbuffer;
  logic              RXready;
  logic [7:0]        TXbuffer;
  logic              TXstart;
  logic              TXbusy;
  logic [DATA_W-1:0] ALUa;
  logic [DATA_W-1:0] ALUb;
  logic [OP_W-1:0]   ALUop;
  logic              ALUstart;
  logic [DATA_W-1:0] ALUresult;
  logic              ALUoverflow;
  logic              ALUdone;
  logic              busy;
  logic              frame_err;

  modport master (
    input  RXbuffer, RXready, TXbusy, ALUresult, ALUoverflow, ALUdone,
    output TXbuffer, TXstart, ALUa, ALUb, ALUop, ALUstart, busy, frame_err
  );

  modport slave (
    output RXbuffer, RXready, TXbusy, ALUresult, ALUoverflow, ALUdone,
    input  TXbuffer, TXstart, ALUa, ALUb, ALUop, ALUstart, busy, frame_err
  );
endinterface

// File: rtl/uart_word_serializer.sv
// Sends a DATA_W-bit word over the UART as DATA_W/8 bytes, LSB first.
// Ports:
//   CLK, RSTN   clock, synchronous active-low reset
//   load_i      one-cycle strobe: capture word_i and start sending
//   word_i      word to send
//   tx_busy_i   UART transmitter busy
//   tx_byte_o   byte to transmit (valid with tx_start_o)
//   tx_start_o  one-cycle transmit request
//   done_o      one-cycle strobe after the last byte has been acknowledged
module uart_word_serializer
  import alu_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              tx_busy_i,
  output logic [7:0]        tx_byte_o,
  output logic              tx_start_o,
  output logic              done_o
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = idx_width(NB);

  bridge_state_e     state_q;
  logic [DATA_W-1:0] word_q;
  logic [IdxW-1:0]   idx_q;
  logic              seen_busy_q;
  logic [7:0]        tx_byte_q;
  logic              tx_start_q;
  logic              done_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      word_q      <= '0;
      idx_q       <= '0;
      seen_busy_q <= 1'b0;
      tx_byte_q   <= '0;
      tx_start_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
            // Issue byte 0 straight away so TXstart follows the load by one cycle
            if (!tx_busy_i) begin
              tx_byte_q   <= word_i[7:0];
              tx_start_q  <= 1'b1;
              seen_busy_q <= 1'b0;
              state_q     <= StTxAck;
            end else begin
              state_q <= StTxByte;
            end
          end
        end
        StTxByte: begin
          if (!tx_busy_i) begin
            tx_byte_q   <= word_q[{idx_q, 3'b000} +: 8];
            tx_start_q  <= 1'b1;
            seen_busy_q <= 1'b0;
            state_q     <= StTxAck;
          end
        end
        StTxAck: begin
          // The transmitter may raise busy several cycles after the request
          if (!seen_busy_q) begin
            if (tx_busy_i) seen_busy_q <= 1'b1;
          end else if (!tx_busy_i) begin
            if (idx_q == IdxW'(NB - 1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StTxByte;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_byte_o  = tx_byte_q;
  assign tx_start_o = tx_start_q;
  assign done_o     = done_q;

endmodule

// File: rtl/alu_uart_bridge.sv
// Byte-serial command bridge: collects {cmd, A, B} from the UART receive stream,
// runs one ALU operation, then returns the result bytes and a status byte.
// Optional feature: define BRIDGE_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES cycles without a byte.
// Ports:
//   CLK, RSTN  clock, synchronous active-low reset
//   bus        alu_uart_bridge_if.master: RX byte stream, TX request/busy,
//              ALU operands/start/result/done, busy and frame_err outputs
module alu_uart_bridge
  import alu_bridge_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned OP_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic               CLK,
  input logic               RSTN,
  alu_uart_bridge_if.master bus
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = idx_width(NB);

  bridge_state_e     state_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] alua_q;
  logic [DATA_W-1:0] alub_q;
  logic [OP_W-1:0]   aluop_q;
  logic              alustart_q;
  logic              frame_err_q;
  logic [7:0]        stat_q;
  logic              stat_start_q;
  logic              stat_seen_busy_q;

  logic              ser_load;
  logic [7:0]        ser_tx_byte;
  logic              ser_tx_start;
  logic              ser_done;
  logic              last_byte;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign last_byte = (idx_q == IdxW'(NB - 1));
  // ALUdone is only honoured in WAIT_ALU; a done during EXEC is dropped
  assign ser_load  = (state_q == StWaitAlu) && bus.ALUdone;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q          <= StIdle;
      idx_q            <= '0;
      alua_q           <= '0;
      alub_q           <= '0;
      aluop_q          <= '0;
      alustart_q       <= 1'b0;
      frame_err_q      <= 1'b0;
      stat_q           <= '0;
      stat_start_q     <= 1'b0;
      stat_seen_busy_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      tmo_q            <= '0;
`endif
    end else begin
      alustart_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      stat_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.RXready) begin
            if ((bus.RXbuffer >> OP_W) != 8'h00) begin
              frame_err_q <= 1'b1;
              stat_q      <= ERR_RESERVED;
              state_q     <= StTxStat;
            end else begin
              aluop_q <= bus.RXbuffer[OP_W-1:0];
              idx_q   <= '0;
              state_q <= StRxA;
            end
          end
        end
        StRxA: begin
          if (bus.RXready) begin
            alua_q[{idx_q, 3'b000} +: 8] <= bus.RXbuffer;
            if (last_byte) begin
              idx_q   <= '0;
              state_q <= StRxB;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StRxB: begin
          if (bus.RXready) begin
            alub_q[{idx_q, 3'b000} +: 8] <= bus.RXbuffer;
            if (last_byte) begin
              idx_q      <= '0;
              alustart_q <= 1'b1;
              state_q    <= StExec;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StExec: state_q <= StWaitAlu;
        StWaitAlu: begin
          if (bus.ALUdone) begin
            stat_q            <= '0;
            stat_q[STAT_ZERO] <= (bus.ALUresult == '0);
            stat_q[STAT_OVF]  <= bus.ALUoverflow;
            idx_q             <= '0;
            state_q           <= StTxByte;
          end
        end
        // Result bytes are being sent by the serializer
        StTxByte: begin
          if (ser_done) state_q <= StTxStat;
        end
        StTxStat: begin
          if (!bus.TXbusy) begin
            stat_start_q     <= 1'b1;
            stat_seen_busy_q <= 1'b0;
            state_q          <= StTxStatAck;
          end
        end
        StTxStatAck: begin
          if (!stat_seen_busy_q) begin
            if (bus.TXbusy) stat_seen_busy_q <= 1'b1;
          end else if (!bus.TXbusy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

`ifdef BRIDGE_TIMEOUT_EN
      // Counts silent cycles inside a frame; held at zero elsewhere
      if ((state_q == StRxA) || (state_q == StRxB)) begin
        if (bus.RXready) begin
          tmo_q <= '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          tmo_q       <= '0;
          idx_q       <= '0;
          frame_err_q <= 1'b1;
          state_q     <= StIdle;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

  uart_word_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .load_i    (ser_load),
    .word_i    (bus.ALUresult),
    .tx_busy_i (bus.TXbusy),
    .tx_byte_o (ser_tx_byte),
    .tx_start_o(ser_tx_start),
    .done_o    (ser_done)
  );

  assign bus.TXbuffer  = ((state_q == StTxStat) || (state_q == StTxStatAck)) ? stat_q
                                                                             : ser_tx_byte;
  assign bus.TXstart   = ser_tx_start | stat_start_q;
  assign bus.ALUa      = alua_q;
  assign bus.ALUb      = alub_q;
  assign bus.ALUop     = aluop_q;
  assign bus.ALUstart  = alustart_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_alu_uart_bridge.sv
// Bench for alu_uart_bridge: 16-bit and 32-bit instances, directed frames,
// a transaction-level model of expected TX bytes and ALU operands.
module tb_alu_uart_bridge;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_uart_bridge_if #(.DATA_W(16), .OP_W(2)) bus16 ();
  alu_uart_bridge_if #(.DATA_W(32), .OP_W(2)) b32 ();

  alu_uart_bridge #(.DATA_W(16), .OP_W(2), .TIMEOUT_CYCLES(100)) u_dut16 (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus16)
  );

  alu_uart_bridge #(.DATA_W(32), .OP_W(2), .TIMEOUT_CYCLES(100)) u_dut32 (
    .CLK (clk),
    .RSTN(rstn),
    .bus (b32)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state (16-bit instance)
  logic [7:0]  exp_tx[$];
  logic [7:0]  rec[$];
  logic [7:0]  rec32[$];
  logic [15:0] m_a = '0, m_b = '0;
  logic [1:0]  m_op = '0;
  int alustart_due = -1;
  int txstart_due = -1;
  int err_seen = 0;
  int exp_err = 0;
  int alu_lat = 5;
  int tx_delay = 0;
  bit inject_early = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: runs just after every active edge
  logic prev_txstart = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (bus16.ALUstart || (cyc == alustart_due)) begin
          check("alustart_timing", bus16.ALUstart, (cyc == alustart_due));
          if (bus16.ALUstart) begin
            check("alu_a", bus16.ALUa, m_a);
            check("alu_b", bus16.ALUb, m_b);
            check("alu_op", bus16.ALUop, m_op);
          end
        end
        if (cyc == txstart_due) check("tx_first_latency", bus16.TXstart, 1);
        if (bus16.TXstart) begin
          check("tx_not_back_to_back", prev_txstart, 0);
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte %0h expected no transmit", bus16.TXbuffer);
          end else begin
            check("tx_byte", bus16.TXbuffer, exp_tx.pop_front());
          end
        end
        if (bus16.frame_err) err_seen++;
        prev_txstart = bus16.TXstart;
      end
    end
  end

  // ALU stand-in (16-bit): op 1 subtracts, others add; overflow = carry/borrow
  initial begin
    logic [16:0] full;
    bus16.ALUdone = 1'b0;
    bus16.ALUresult = '0;
    bus16.ALUoverflow = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && bus16.ALUstart) begin
        for (int i = 0; i < alu_lat; i++) begin
          if (i == 0 && inject_early) begin
            bus16.ALUdone = 1'b1;
            bus16.ALUresult = 16'hBEEF;
            bus16.ALUoverflow = 1'b1;
          end
          @(negedge clk);
          bus16.ALUdone = 1'b0;
        end
        if (m_op == 2'd1) full = {1'b0, m_a} - {1'b0, m_b};
        else full = {1'b0, m_a} + {1'b0, m_b};
        bus16.ALUresult = full[15:0];
        bus16.ALUoverflow = full[16];
        bus16.ALUdone = 1'b1;
        exp_tx.push_back(full[7:0]);
        exp_tx.push_back(full[15:8]);
        exp_tx.push_back({6'b0, (full[15:0] == 16'h0), full[16]});
        if (!bus16.TXbusy) txstart_due = cyc + 1;
        @(negedge clk);
        bus16.ALUdone = 1'b0;
      end
    end
  end

  // UART transmitter stand-in (16-bit): busy rises tx_delay cycles late, lasts 3
  initial begin
    bus16.TXbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus16.TXstart) begin
        rec.push_back(bus16.TXbuffer);
        repeat (tx_delay) @(negedge clk);
        bus16.TXbusy = 1'b1;
        repeat (3) @(negedge clk);
        bus16.TXbusy = 1'b0;
      end
    end
  end

  // 32-bit environment: fixed ALU answer, short busy
  initial begin
    b32.ALUdone = 1'b0;
    b32.ALUresult = '0;
    b32.ALUoverflow = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && b32.ALUstart) begin
        check("a32_operand_a", b32.ALUa, 64'h12345678);
        check("a32_operand_b", b32.ALUb, 64'h1);
        check("a32_opcode", b32.ALUop, 64'h1);
        repeat (3) @(negedge clk);
        b32.ALUresult = 32'h12345677;
        b32.ALUdone = 1'b1;
        @(negedge clk);
        b32.ALUdone = 1'b0;
      end
    end
  end

  initial begin
    b32.TXbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (b32.TXstart) begin
        rec32.push_back(b32.TXbuffer);
        b32.TXbusy = 1'b1;
        repeat (2) @(negedge clk);
        b32.TXbusy = 1'b0;
      end
    end
  end

  task automatic send_byte(input bit which, input logic [7:0] b, input bit last);
    @(negedge clk);
    if (which) begin
      b32.RXbuffer = b;
      b32.RXready = 1'b1;
    end else begin
      bus16.RXbuffer = b;
      bus16.RXready = 1'b1;
      if (last) alustart_due = cyc + 1;
    end
    @(negedge clk);
    bus16.RXready = 1'b0;
    b32.RXready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b);
    if (cmd[7:2] != 6'd0) begin
      exp_tx.push_back(8'h80);
      exp_err++;
      send_byte(0, cmd, 0);
    end else begin
      m_op = cmd[1:0];
      m_a = a;
      m_b = b;
      send_byte(0, cmd, 0);
      send_byte(0, a[7:0], 0);
      send_byte(0, a[15:8], 0);
      send_byte(0, b[7:0], 0);
      send_byte(0, b[15:8], 1);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus16.busy && !bus16.TXbusy && exp_tx.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  // Compare recorded bytes against a literal list packed LSB-first
  task automatic check_rec(input string name, input bit which, input int n,
                           input logic [39:0] exp);
    int sz;
    sz = which ? rec32.size() : rec.size();
    check({name, "_count"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) check(name, which ? rec32[i] : rec[i], exp[8*i +: 8]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus16.RXbuffer = '0;
    bus16.RXready = 1'b0;
    b32.RXbuffer = '0;
    b32.RXready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txbuffer", bus16.TXbuffer, 0);
    check("rst_txstart", bus16.TXstart, 0);
    check("rst_alua", bus16.ALUa, 0);
    check("rst_alub", bus16.ALUb, 0);
    check("rst_aluop", bus16.ALUop, 0);
    check("rst_alustart", bus16.ALUstart, 0);
    check("rst_busy", bus16.busy, 0);
    check("rst_frame_err", bus16.frame_err, 0);
    check("rst32_alua", b32.ALUa, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: 0x1234 + 0x0001
    rec.delete();
    alu_lat = 5;
    tx_delay = 0;
    send_frame(8'h00, 16'h1234, 16'h0001);
    wait_idle("f1_complete");
    check_rec("f1_tx", 0, 3, 40'h00_00_00_12_35);
    check("f1_alua", bus16.ALUa, 16'h1234);
    check("f1_alub", bus16.ALUb, 16'h0001);
    check("f1_aluop", bus16.ALUop, 0);

    // Frame 2: zero result with overflow, late TXbusy rise
    rec.delete();
    tx_delay = 2;
    send_frame(8'h03, 16'hFFFF, 16'h0001);
    wait_idle("f2_complete");
    check_rec("f2_tx", 0, 3, 40'h00_00_03_00_00);
    check("f2_aluop", bus16.ALUop, 3);

    // Reserved bits set: error status only, operands held
    rec.delete();
    tx_delay = 0;
    send_frame(8'h84, 16'h0, 16'h0);
    wait_idle("err_complete");
    check_rec("err_tx", 0, 1, 40'h80);
    check("err_count", err_seen, exp_err);
    check("err_aluop_held", bus16.ALUop, 3);
    check("err_alua_held", bus16.ALUa, 16'hFFFF);

    // Next frame accepted; a done during EXEC must be ignored
    rec.delete();
    inject_early = 1'b1;
    alu_lat = 3;
    send_frame(8'h01, 16'h0010, 16'h0003);
    wait_idle("f3_complete");
    inject_early = 1'b0;
    check_rec("f3_tx", 0, 3, 40'h00_00_00_00_0D);

`ifdef BRIDGE_TIMEOUT_EN
    // Partial frame then silence
    rec.delete();
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h34, 0);
    exp_err++;
    repeat (120) @(negedge clk);
    check("tmo_err_count", err_seen, exp_err);
    check("tmo_busy", bus16.busy, 0);
    check("tmo_no_tx", rec.size(), 0);
`endif

    // Reset during TX_ACK of the first result byte
    rec.delete();
    alu_lat = 2;
    send_frame(8'h00, 16'h0002, 16'h0003);
    for (int i = 0; i < 100 && rec.size() == 0; i++) @(negedge clk);
    check("rst_mid_first_byte", rec.size(), 1);
    rstn = 1'b0;
    exp_tx.delete();
    txstart_due = -1;
    alustart_due = -1;
    @(negedge clk);
    rstn = 1'b1;
    check("rstmid_txbuffer", bus16.TXbuffer, 0);
    check("rstmid_txstart", bus16.TXstart, 0);
    check("rstmid_alua", bus16.ALUa, 0);
    check("rstmid_alub", bus16.ALUb, 0);
    check("rstmid_aluop", bus16.ALUop, 0);
    check("rstmid_alustart", bus16.ALUstart, 0);
    check("rstmid_busy", bus16.busy, 0);
    check("rstmid_frame_err", bus16.frame_err, 0);
    repeat (40) @(negedge clk);
    check("rstmid_no_more_tx", rec.size(), 1);
    check("rstmid_err_count", err_seen, exp_err);

    // 32-bit instance: 0x12345678 - 1
    rec32.delete();
    send_byte(1, 8'h01, 0);
    send_byte(1, 8'h78, 0);
    send_byte(1, 8'h56, 0);
    send_byte(1, 8'h34, 0);
    send_byte(1, 8'h12, 0);
    send_byte(1, 8'h01, 0);
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h00, 0);
    for (int i = 0; i < 300 && (rec32.size() < 5 || b32.busy); i++) @(negedge clk);
    check_rec("w32_tx", 1, 5, 40'h00_12_34_56_77);
    check("w32_busy", b32.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
